symmetry_scan_sequencer: RTL and testbench

//  Sequences a raster pixel stream into symmetry_monitor: generates valid_pixel/end_of_line/x_coord,

---
 rtl/symmetry_scan_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_symmetry_scan_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/symmetry_scan_sequencer.sv
// symmetry_scan_sequencer
//   Frames a raster pixel stream for symmetry_monitor (valid/EOL/x/center),
//   inserts the FLUSH/EOL/EVAL dead cycles after each line, thresholds and
//   debounces the monitor metrics, and issues the reflex trigger.
//   Optional feature macro: SYM_SEQ_SPREAD_CHECK_EN (adds the spread check and
//   widens reflex_cause to 3 bits).
module symmetry_scan_sequencer #(
    parameter int LINE_WIDTH      = 640,
    parameter int LINES_PER_FRAME = 480,
    parameter int DEBOUNCE        = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [9:0]         cfg_center_x,
    input  logic [23:0]        cfg_drift_thr,
    input  logic [23:0]        cfg_jerk_thr,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_pixel,
    input  logic               s_sof,
    output logic               mon_valid_pixel,
    output logic               mon_end_of_line,
    output logic [7:0]         mon_pixel_val,
    output logic [9:0]         mon_x_coord,
    output logic [9:0]         mon_center_x,
    input  logic signed [23:0] mon_drift,
    input  logic signed [23:0] mon_jerk,
`ifdef SYM_SEQ_SPREAD_CHECK_EN
    input  logic signed [31:0] mon_spread,
    input  logic [31:0]        cfg_spread_thr,
    output logic [2:0]         reflex_cause,
`else
    output logic [1:0]         reflex_cause,
`endif
    output logic               reflex_trigger,
    output logic               reflex_dir,
    output logic               frame_done,
    output logic [8:0]         line_count,
    output logic               sync_err
);

`ifdef SYM_SEQ_SPREAD_CHECK_EN
    localparam int CAUSE_W = 3;
`else
    localparam int CAUSE_W = 2;
`endif
    localparam int              CNT_W     = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [9:0]      X_LAST    = 10'(LINE_WIDTH - 1);
    localparam logic [8:0]      LINE_LAST = 9'(LINES_PER_FRAME - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_EOL,
        ST_EVAL,
        ST_ABORT
    } state_t;

    // Magnitude of a 24-bit signed metric; the most negative value saturates.
    function automatic logic [23:0] abs_sat24(input logic signed [23:0] v);
        logic [23:0] r;
        if (!v[23])              r = $unsigned(v);
        else if (v[22:0] == '0)  r = 24'h7F_FFFF;
        else                     r = $unsigned(-v);
        return r;
    endfunction

`ifdef SYM_SEQ_SPREAD_CHECK_EN
    // Magnitude of a 32-bit signed metric; the most negative value saturates.
    function automatic logic [31:0] abs_sat32(input logic signed [31:0] v);
        logic [31:0] r;
        if (!v[31])              r = $unsigned(v);
        else if (v[30:0] == '0)  r = 32'h7FFF_FFFF;
        else                     r = $unsigned(-v);
        return r;
    endfunction
`endif

    state_t               state_q, state_d;
    logic [9:0]           x_q, x_d;
    logic [8:0]           line_q, line_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [9:0]           center_q, center_d;
    logic                 mvalid_q, mvalid_d;
    logic                 meol_q, meol_d;
    logic [7:0]           mpix_q, mpix_d;
    logic [9:0]           mx_q, mx_d;
    logic                 trig_q, trig_d;
    logic                 dir_q, dir_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic                 fdone_q, fdone_d;
    logic                 serr_q, serr_d;

    logic                 accept;
    logic                 drift_over, jerk_over, spread_over;
    logic                 drift_hit;
    logic [CNT_W-1:0]     cnt_eval;

    // Ready depends only on state (and enable while idle), never on s_* inputs.
    always_comb begin
        s_ready = 1'b0;
        if (state_q == ST_IDLE)      s_ready = enable;
        else if (state_q == ST_SCAN) s_ready = 1'b1;
    end

    assign accept = s_valid & s_ready;

    // Threshold comparisons and debounce update used in the EVAL cycle.
    always_comb begin
        drift_over = abs_sat24(mon_drift) > cfg_drift_thr;
        jerk_over  = abs_sat24(mon_jerk)  > cfg_jerk_thr;
`ifdef SYM_SEQ_SPREAD_CHECK_EN
        spread_over = abs_sat32(mon_spread) > cfg_spread_thr;
`else
        spread_over = 1'b0;
`endif
        cnt_eval = '0;
        if (drift_over) cnt_eval = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        drift_hit = drift_over && (cnt_eval == CNT_MAX);
    end

    // Next-state and registered-output computation for the line sequencer.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        line_d   = line_q;
        cnt_d    = cnt_q;
        center_d = center_q;
        mvalid_d = 1'b0;
        meol_d   = 1'b0;
        mpix_d   = mpix_q;
        mx_d     = mx_q;
        trig_d   = 1'b0;
        dir_d    = dir_q;
        cause_d  = cause_q;
        fdone_d  = 1'b0;
        serr_d   = serr_q;

        case (state_q)
            ST_IDLE: begin
                if (!enable) serr_d = 1'b0;
                // The SOF beat is pixel 0 of line 0; other beats are dropped.
                if (accept && s_sof) begin
                    center_d = cfg_center_x;
                    cnt_d    = '0;
                    line_d   = '0;
                    mvalid_d = 1'b1;
                    mpix_d   = s_pixel;
                    mx_d     = '0;
                    if (X_LAST == 10'd0) begin
                        x_d     = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        x_d     = 10'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (accept) begin
                    if (s_sof && (x_q != '0 || line_q != '0)) begin
                        // Misplaced SOF: drop the beat and flush the monitor.
                        serr_d  = 1'b1;
                        cnt_d   = '0;
                        x_d     = '0;
                        meol_d  = 1'b1;
                        state_d = ST_ABORT;
                    end else begin
                        mvalid_d = 1'b1;
                        mpix_d   = s_pixel;
                        mx_d     = x_q;
                        if (x_q == X_LAST) begin
                            x_d     = '0;
                            state_d = ST_FLUSH;
                        end else begin
                            x_d = x_q + 10'd1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                meol_d  = 1'b1;
                state_d = ST_EOL;
            end
            ST_EOL: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                cnt_d = cnt_eval;
                if (drift_hit || jerk_over || spread_over) begin
                    trig_d = 1'b1;
                    dir_d  = ~mon_drift[23];
`ifdef SYM_SEQ_SPREAD_CHECK_EN
                    cause_d = {spread_over, jerk_over, drift_hit};
`else
                    cause_d = {jerk_over, drift_hit};
`endif
                end
                if (line_q == LINE_LAST) begin
                    line_d  = '0;
                    fdone_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    line_d  = line_q + 9'd1;
                    state_d = enable ? ST_SCAN : ST_IDLE;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, all returned to zero by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            line_q   <= '0;
            cnt_q    <= '0;
            center_q <= '0;
            mvalid_q <= 1'b0;
            meol_q   <= 1'b0;
            mpix_q   <= '0;
            mx_q     <= '0;
            trig_q   <= 1'b0;
            dir_q    <= 1'b0;
            cause_q  <= '0;
            fdone_q  <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            line_q   <= line_d;
            cnt_q    <= cnt_d;
            center_q <= center_d;
            mvalid_q <= mvalid_d;
            meol_q   <= meol_d;
            mpix_q   <= mpix_d;
            mx_q     <= mx_d;
            trig_q   <= trig_d;
            dir_q    <= dir_d;
            cause_q  <= cause_d;
            fdone_q  <= fdone_d;
            serr_q   <= serr_d;
        end
    end

    assign mon_valid_pixel = mvalid_q;
    assign mon_end_of_line = meol_q;
    assign mon_pixel_val   = mpix_q;
    assign mon_x_coord     = mx_q;
    assign mon_center_x    = center_q;
    assign reflex_trigger  = trig_q;
    assign reflex_dir      = dir_q;
    assign reflex_cause    = cause_q;
    assign frame_done      = fdone_q;
    assign line_count      = line_q;
    assign sync_err        = serr_q;

endmodule

// File: tb/tb_symmetry_scan_sequencer.sv
// Directed bench for symmetry_scan_sequencer (LINE_WIDTH=8, 4 lines/frame).
module tb_symmetry_scan_sequencer;

    localparam int LW = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [9:0]         cfg_center_x;
    logic [23:0]        cfg_drift_thr;
    logic [23:0]        cfg_jerk_thr;
    logic               s_valid;
    logic               s_ready;
    logic [7:0]         s_pixel;
    logic               s_sof;
    logic               mon_valid_pixel;
    logic               mon_end_of_line;
    logic [7:0]         mon_pixel_val;
    logic [9:0]         mon_x_coord;
    logic [9:0]         mon_center_x;
    logic signed [23:0] mon_drift;
    logic signed [23:0] mon_jerk;
    logic               reflex_trigger;
    logic               reflex_dir;
    logic [1:0]         reflex_cause;
    logic               frame_done;
    logic [8:0]         line_count;
    logic               sync_err;

    int nvec = 0;
    int nerr = 0;
    logic [9:0] exp_center;

    symmetry_scan_sequencer #(
        .LINE_WIDTH(LW), .LINES_PER_FRAME(4), .DEBOUNCE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_center_x(cfg_center_x), .cfg_drift_thr(cfg_drift_thr), .cfg_jerk_thr(cfg_jerk_thr),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel), .s_sof(s_sof),
        .mon_valid_pixel(mon_valid_pixel), .mon_end_of_line(mon_end_of_line),
        .mon_pixel_val(mon_pixel_val), .mon_x_coord(mon_x_coord), .mon_center_x(mon_center_x),
        .mon_drift(mon_drift), .mon_jerk(mon_jerk),
        .reflex_cause(reflex_cause), .reflex_trigger(reflex_trigger), .reflex_dir(reflex_dir),
        .frame_done(frame_done), .line_count(line_count), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One line of LW beats with continuous valid; checks framing, dead cycles and trigger.
    task automatic run_line(input bit sof, input int ln,
                            input logic signed [23:0] drift, input logic signed [23:0] jerk,
                            input bit exp_trig, input bit exp_dir, input logic [1:0] exp_cause,
                            input bit last, input int abort_k);
        logic [7:0] pix;
        int guard;
        mon_drift = drift;
        mon_jerk  = jerk;
        for (int k = 0; k < LW; k++) begin
            pix     = 8'(ln * 16 + k + 1);
            s_valid = 1'b1;
            s_pixel = pix;
            s_sof   = (sof && k == 0) || (k == abort_k);
            guard   = 0;
            while (!s_ready && guard < 20) begin
                step();
                guard++;
            end
            if (guard >= 20) begin
                chk("ready_wait", 32'(s_ready), 32'd1);
                return;
            end
            step();
            if (k == abort_k) begin
                chk("abort_eol", 32'(mon_end_of_line), 32'd1);
                chk("abort_valid", 32'(mon_valid_pixel), 32'd0);
                chk("abort_sync_err", 32'(sync_err), 32'd1);
                chk("abort_ready", 32'(s_ready), 32'd0);
                s_valid = 1'b0;
                s_sof   = 1'b0;
                step();
                chk("abort_eol_once", 32'(mon_end_of_line), 32'd0);
                chk("abort_no_trig", 32'(reflex_trigger), 32'd0);
                chk("abort_line_hold", 32'(line_count), 32'(ln));
                chk("abort_idle_ready", 32'(s_ready), 32'(enable));
                chk("abort_sync_sticky", 32'(sync_err), 32'd1);
                return;
            end
            chk("pix_valid", 32'(mon_valid_pixel), 32'd1);
            chk("pix_x", 32'(mon_x_coord), 32'(k));
            chk("pix_val", 32'(mon_pixel_val), 32'(pix));
            chk("pix_no_eol", 32'(mon_end_of_line), 32'd0);
            if (k == 0) begin
                chk("line_idx", 32'(line_count), 32'(ln));
                chk("center", 32'(mon_center_x), 32'(exp_center));
            end
        end
        s_sof = 1'b0;
        chk("flush_ready", 32'(s_ready), 32'd0);
        step();
        chk("eol_pulse", 32'(mon_end_of_line), 32'd1);
        chk("eol_no_valid", 32'(mon_valid_pixel), 32'd0);
        chk("eol_ready", 32'(s_ready), 32'd0);
        step();
        chk("eval_ready", 32'(s_ready), 32'd0);
        chk("eval_eol_low", 32'(mon_end_of_line), 32'd0);
        step();
        chk("trig", 32'(reflex_trigger), 32'(exp_trig));
        chk("frame_done", 32'(frame_done), 32'(last));
        chk("ready_after", 32'(s_ready), 32'(enable));
        if (exp_trig) begin
            chk("dir", 32'(reflex_dir), 32'(exp_dir));
            chk("cause", 32'(reflex_cause), 32'(exp_cause));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0;
        cfg_center_x = 10'd100; cfg_drift_thr = 24'd500; cfg_jerk_thr = 24'd500;
        s_valid = 1'b0; s_pixel = '0; s_sof = 1'b0;
        mon_drift = '0; mon_jerk = '0;
        exp_center = 10'd100;
        repeat (3) step();
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_valid", 32'(mon_valid_pixel), 32'd0);
        chk("rst_eol", 32'(mon_end_of_line), 32'd0);
        chk("rst_line", 32'(line_count), 32'd0);
        chk("rst_center", 32'(mon_center_x), 32'd0);
        chk("rst_trig", 32'(reflex_trigger), 32'd0);
        chk("rst_cause", 32'(reflex_cause), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ready_off", 32'(s_ready), 32'd0);
        enable = 1'b1;
        #1;
        chk("idle_ready_on", 32'(s_ready), 32'd1);

        // Frame 1: drift debounce, retrigger, saturated negative drift
        run_line(1, 0, 24'sd1000, 24'sd0, 0, 0, 2'b00, 0, -1);
        run_line(0, 1, 24'sd1000, 24'sd0, 1, 1, 2'b01, 0, -1);
        run_line(0, 2, 24'sd1000, 24'sd0, 1, 1, 2'b01, 0, -1);
        cfg_drift_thr = 24'h7F_FFFE;
        run_line(0, 3, 24'sh80_0000, 24'sd0, 1, 0, 2'b01, 1, -1);

        // Frame 2: count cleared at SOF, jerk-only and combined causes
        cfg_drift_thr = 24'd500;
        cfg_center_x  = 10'd200; exp_center = 10'd200;
        run_line(1, 0, 24'sd1000, 24'sd0, 0, 0, 2'b00, 0, -1);
        run_line(0, 1, 24'sd100, 24'sd600, 1, 1, 2'b10, 0, -1);
        run_line(0, 2, -24'sd1000, 24'sd0, 0, 0, 2'b00, 0, -1);
        run_line(0, 3, -24'sd1000, -24'sd600, 1, 0, 2'b11, 1, -1);

        // Frame 3: saturated value at exact threshold, then misplaced SOF at x=3
        cfg_drift_thr = 24'h7F_FFFF;
        cfg_center_x  = 10'd300; exp_center = 10'd300;
        run_line(1, 0, 24'sh80_0000, 24'sd0, 0, 0, 2'b00, 0, -1);
        run_line(0, 1, 24'sh80_0000, 24'sd0, 0, 0, 2'b00, 0, 3);

        // Frame 4: restart after abort, then enable dropped mid-frame
        cfg_drift_thr = 24'd500;
        cfg_center_x  = 10'd400; exp_center = 10'd400;
        run_line(1, 0, 24'sd1000, 24'sd0, 0, 0, 2'b00, 0, -1);
        enable = 1'b0;
        run_line(0, 1, 24'sd1000, 24'sd0, 1, 1, 2'b01, 0, -1);
        s_valid = 1'b0;
        step();
        chk("parked_ready", 32'(s_ready), 32'd0);
        chk("sync_err_cleared", 32'(sync_err), 32'd0);

        // Asynchronous reset in the middle of a line
        enable = 1'b1;
        s_valid = 1'b1; s_sof = 1'b1; s_pixel = 8'hA5;
        step();
        chk("rst2_pre_valid", 32'(mon_valid_pixel), 32'd1);
        s_sof = 1'b0;
        step();
        step();
        chk("rst2_pre_x", 32'(mon_x_coord), 32'd2);
        #2;
        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0;
        #1;
        chk("rst2_valid", 32'(mon_valid_pixel), 32'd0);
        chk("rst2_x", 32'(mon_x_coord), 32'd0);
        chk("rst2_pixel", 32'(mon_pixel_val), 32'd0);
        chk("rst2_center", 32'(mon_center_x), 32'd0);
        chk("rst2_dir", 32'(reflex_dir), 32'd0);
        chk("rst2_cause", 32'(reflex_cause), 32'd0);
        chk("rst2_ready", 32'(s_ready), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst2_idle_ready", 32'(s_ready), 32'd0);
        enable = 1'b1;
        #1;
        chk("rst2_enable_ready", 32'(s_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
